// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: default widths, Gray/binary
// pointer conversion and the output-buffer state encoding.
package fifo_pkg;

   localparam int ADDR_SIZE_DEF = 4;
   localparam int DATA_SIZE_DEF = 8;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_TWO   = 2'd2
   } buf_state_e;

   // Zero-extended operands make both conversions width-independent: callers
   // widen their pointer to 32 bits and size-cast the result back.
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_read_ctrl_if.sv
// Read-side bus of the asynchronous FIFO: synchronised write pointer, RAM read
// port and the downstream valid/ready stream.
interface fifo_read_ctrl_if #(
   parameter int ADDR_SIZE = 4,
   parameter int DATA_SIZE = 8
);
   logic [ADDR_SIZE:0]   RQ2_WPTR;
   logic [ADDR_SIZE:0]   RPTR;
   logic [ADDR_SIZE-1:0] RADDR;
   logic                 REN;
   logic [DATA_SIZE-1:0] RDATA_MEM;
   logic [DATA_SIZE-1:0] RDATA;
   logic                 RVALID;
   logic                 RREADY;
   logic                 REMPTY;
   logic                 RAEMPTY;
   logic [ADDR_SIZE:0]   RLEVEL;

   modport slave (
      input  RQ2_WPTR, RDATA_MEM, RREADY,
      output RPTR, RADDR, REN, RDATA, RVALID, REMPTY, RAEMPTY, RLEVEL
   );

   modport master (
      output RQ2_WPTR, RDATA_MEM, RREADY,
      input  RPTR, RADDR, REN, RDATA, RVALID, REMPTY, RAEMPTY, RLEVEL
   );

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer between the registered RAM read and the downstream
// stream; head word is presented registered and held while not popped.
module fifo_rd_skid
   import fifo_pkg::*;
#(
   parameter int DATA_SIZE = DATA_SIZE_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push_i,
   input  logic [DATA_SIZE-1:0] push_dat_i,
   input  logic                 pop_i,
   output logic                 vld_o,
   output logic [DATA_SIZE-1:0] dat_o,
   output logic [1:0]           bcnt_o
);

   buf_state_e           state_q, state_d;
   logic [DATA_SIZE-1:0] head_q, head_d;
   logic [DATA_SIZE-1:0] tail_q, tail_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BUF_EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         BUF_EMPTY: begin
            if (push_i) begin
               state_d = BUF_ONE;
               head_d  = push_dat_i;
            end
         end
         BUF_ONE: begin
            if (push_i && !pop_i) begin
               state_d = BUF_TWO;
               tail_d  = push_dat_i;
            end else if (push_i && pop_i) begin
               head_d  = push_dat_i;
            end else if (pop_i) begin
               state_d = BUF_EMPTY;
            end
         end
         BUF_TWO: begin
            // The fetch throttle keeps push low here, so only a pop can occur.
            if (pop_i) begin
               state_d = BUF_ONE;
               head_d  = tail_q;
            end
         end
         default: begin
            state_d = BUF_EMPTY;
         end
      endcase
   end

   assign vld_o  = (state_q != BUF_EMPTY);
   assign dat_o  = head_q;
   assign bcnt_o = state_q;

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-domain controller of the async FIFO: Gray/binary read pointer, empty and
// level flags, RAM read issue and prefetch into a 2-entry output buffer.
module fifo_read_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_SIZE     = ADDR_SIZE_DEF,
   parameter int DATA_SIZE     = DATA_SIZE_DEF,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic            RCLK,
   input  logic            RRST,
   fifo_read_ctrl_if.slave bus
);

   localparam int PW = ADDR_SIZE + 1;

   logic [PW-1:0]        rbin_q, rbin_d;
   logic [PW-1:0]        rptr_q, rptr_d;
   logic                 rempty_q, rempty_d;
   logic                 raempty_q, raempty_d;
   logic [PW-1:0]        rlevel_q, rlevel_d;
   logic                 pend_q, pend_d;

   logic [PW-1:0]        wbin;
   logic                 ren;
   logic                 pop;
   logic                 rvalid;
   logic [DATA_SIZE-1:0] rdata;
   logic [1:0]           bcnt;
   logic [2:0]           occ_next;

   assign wbin = PW'(gray2bin(32'(bus.RQ2_WPTR)));
   assign pop  = rvalid && bus.RREADY;

   // Buffer occupancy once this cycle's push and pop settle; never exceeds 2.
   assign occ_next = {1'b0, bcnt} + {2'b00, pend_q} - {2'b00, pop};

   // Fetch only if the slot the returning word needs is guaranteed free.
   assign ren = !rempty_q && (occ_next <= 3'd1);

   always_comb begin
      rbin_d    = rbin_q + PW'(ren);
      rptr_d    = PW'(bin2gray(32'(rbin_d)));
      rempty_d  = (rptr_d == bus.RQ2_WPTR);
      pend_d    = ren;
      rlevel_d  = (wbin - rbin_d) + PW'(pend_d) + PW'(occ_next[1:0]);
      raempty_d = (rlevel_d <= PW'(AEMPTY_THRESH));
   end

   always_ff @(posedge RCLK or posedge RRST) begin
      if (RRST) begin
         rbin_q    <= '0;
         rptr_q    <= '0;
         rempty_q  <= 1'b1;
         raempty_q <= 1'b1;
         rlevel_q  <= '0;
         pend_q    <= 1'b0;
      end else begin
         rbin_q    <= rbin_d;
         rptr_q    <= rptr_d;
         rempty_q  <= rempty_d;
         raempty_q <= raempty_d;
         rlevel_q  <= rlevel_d;
         pend_q    <= pend_d;
      end
   end

   fifo_rd_skid #(
      .DATA_SIZE (DATA_SIZE)
   ) u_skid (
      .clk        (RCLK),
      .rst        (RRST),
      .push_i     (pend_q),
      .push_dat_i (bus.RDATA_MEM),
      .pop_i      (pop),
      .vld_o      (rvalid),
      .dat_o      (rdata),
      .bcnt_o     (bcnt)
   );

   assign bus.RPTR    = rptr_q;
   assign bus.RADDR   = rbin_q[ADDR_SIZE-1:0];
   assign bus.REN     = ren;
   assign bus.RDATA   = rdata;
   assign bus.RVALID  = rvalid;
   assign bus.REMPTY  = rempty_q;
   assign bus.RAEMPTY = raempty_q;
   assign bus.RLEVEL  = rlevel_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: behavioural write side and registered RAM, with a
// scoreboard of written words checked against every downstream pop.
module tb_fifo_read_ctrl;

   localparam int AS = 4;
   localparam int DS = 8;
   localparam int PW = AS + 1;

   logic RCLK = 1'b0;
   logic RRST = 1'b0;

   always #5 RCLK = ~RCLK;

   fifo_read_ctrl_if #(.ADDR_SIZE(AS), .DATA_SIZE(DS)) bus ();

   fifo_read_ctrl #(
      .ADDR_SIZE     (AS),
      .DATA_SIZE     (DS),
      .AEMPTY_THRESH (2)
   ) dut (
      .RCLK (RCLK),
      .RRST (RRST),
      .bus  (bus)
   );

   logic [DS-1:0] mem [0:(1<<AS)-1];
   logic [PW-1:0] wbin;
   logic [DS-1:0] exp_q [$];
   int            ren_addr [$];
   int            ren_cyc [$];
   int            pop_cyc [$];
   int            ren_cnt;
   int            cyc = 0;
   int            n_tests = 0;
   int            n_fail = 0;
   bit            valid_seen;
   bit            wrap_seen;

   always @(posedge RCLK) begin
      cyc++;
      if (bus.REN) bus.RDATA_MEM <= mem[bus.RADDR];
   end

   task automatic chk(input string tag, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [PW-1:0] from_gray(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   // Observation half a cycle from the active edge: RAM fetches, pops, flags.
   always @(negedge RCLK) begin
      if (!RRST) begin
         if (bus.REN) begin
            ren_cnt++;
            ren_addr.push_back(int'(bus.RADDR));
            ren_cyc.push_back(cyc);
         end
         if (bus.RVALID) valid_seen = 1'b1;
         if (bus.RPTR == 5'b10000) wrap_seen = 1'b1;
         if (dut.bcnt == 2'd2) chk("pend_in_two", int'(dut.pend_q), 0);
         if (bus.RVALID && bus.RREADY) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk("pop_underflow", 1, 0);
            else chk("pop_data", int'(bus.RDATA), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge RCLK);
         #1;
      end
   endtask

   task automatic clear_mon();
      ren_cnt    = 0;
      valid_seen = 1'b0;
      ren_addr.delete();
      ren_cyc.delete();
      pop_cyc.delete();
   endtask

   task automatic do_reset();
      RRST         = 1'b1;
      wbin         = '0;
      bus.RQ2_WPTR = '0;
      bus.RREADY   = 1'b0;
      exp_q.delete();
      step(2);
      RRST = 1'b0;
      step(1);
      clear_mon();
   endtask

   task automatic write_word(input logic [DS-1:0] d);
      mem[wbin[AS-1:0]] = d;
      exp_q.push_back(d);
      wbin         = wbin + 1'b1;
      bus.RQ2_WPTR = to_gray(wbin);
   endtask

   task automatic drain(input int max_cyc);
      int k = 0;
      while (exp_q.size() != 0 && k < max_cyc) begin
         step();
         k++;
      end
      chk("drain_timeout", exp_q.size(), 0);
   endtask

   task automatic pop_one();
      bus.RREADY = 1'b1;
      step();
      bus.RREADY = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rvalid"},  int'(bus.RVALID),  0);
      chk({tag, "_rptr"},    int'(bus.RPTR),    0);
      chk({tag, "_rempty"},  int'(bus.REMPTY),  1);
      chk({tag, "_raempty"}, int'(bus.RAEMPTY), 1);
      chk({tag, "_rlevel"},  int'(bus.RLEVEL),  0);
      chk({tag, "_rdata"},   int'(bus.RDATA),   0);
      chk({tag, "_ren"},     int'(bus.REN),     0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int written;
      int k;

      bus.RQ2_WPTR = '0;
      bus.RREADY   = 1'b0;
      wbin         = '0;
      clear_mon();

      // Reset values while reset is held, then idle with nothing written.
      #1 RRST = 1'b1;
      #1 chk_reset_outputs("rst");
      do_reset();
      step(6);
      chk("idle_ren_cnt", ren_cnt, 0);
      chk("idle_valid_seen", int'(valid_seen), 0);
      chk_reset_outputs("idle");

      // Three words with downstream always ready.
      bus.RREADY = 1'b1;
      for (int i = 0; i < 3; i++) write_word(8'(i));
      drain(20);
      step(3);
      chk("t3_ren_cnt", ren_cnt, 3);
      if (ren_addr.size() == 3) begin
         for (int i = 0; i < 3; i++) chk("t3_raddr", ren_addr[i], i);
      end else chk("t3_raddr_cnt", ren_addr.size(), 3);
      if (pop_cyc.size() == 3 && ren_cyc.size() >= 1) begin
         chk("t3_first_latency", pop_cyc[0] - ren_cyc[0], 2);
         chk("t3_back_to_back", pop_cyc[2] - pop_cyc[0], 2);
      end else chk("t3_pop_cnt", pop_cyc.size(), 3);
      chk("t3_rptr", int'(bus.RPTR), int'(5'b00010));
      chk("t3_rempty", int'(bus.REMPTY), 1);
      chk("t3_rlevel", int'(bus.RLEVEL), 0);

      // Eight words with downstream stalled, then released.
      do_reset();
      for (int i = 0; i < 8; i++) write_word(8'(i));
      step(10);
      chk("t8_ren_cnt", ren_cnt, 2);
      chk("t8_bcnt", int'(dut.bcnt), 2);
      chk("t8_rdata", int'(bus.RDATA), 0);
      chk("t8_rvalid", int'(bus.RVALID), 1);
      chk("t8_rlevel", int'(bus.RLEVEL), 8);
      chk("t8_rempty", int'(bus.REMPTY), 0);
      chk("t8_raempty", int'(bus.RAEMPTY), 0);
      step(5);
      chk("t8_rdata_hold", int'(bus.RDATA), 0);
      chk("t8_ren_hold", ren_cnt, 2);
      pop_cyc.delete();
      bus.RREADY = 1'b1;
      drain(30);
      step(2);
      if (pop_cyc.size() == 8) chk("t8_no_bubbles", pop_cyc[7] - pop_cyc[0], 7);
      else chk("t8_pop_cnt", pop_cyc.size(), 8);

      // Pointer wrap: 37 words through a 16-deep RAM, random downstream stalls.
      do_reset();
      wrap_seen = 1'b0;
      written   = 0;
      k         = 0;
      while ((written < 37 || exp_q.size() != 0) && k < 600) begin
         if (written < 37 && (wbin - from_gray(bus.RPTR)) < 5'd16) begin
            write_word(8'(written));
            written++;
         end
         bus.RREADY = ($urandom_range(0, 3) != 0);
         step();
         k++;
      end
      bus.RREADY = 1'b1;
      step(4);
      chk("wrap_leftover", exp_q.size(), 0);
      chk("wrap_pop_cnt", pop_cyc.size(), 37);
      chk("wrap_seen_10000", int'(wrap_seen), 1);
      chk("wrap_rptr", int'(bus.RPTR), int'(5'b00111));
      chk("wrap_rempty", int'(bus.REMPTY), 1);
      chk("wrap_rlevel", int'(bus.RLEVEL), 0);

      // Level thresholds stepping down by single pops.
      do_reset();
      for (int i = 0; i < 3; i++) write_word(8'(8'h10 + i));
      step(6);
      chk("th3_rlevel", int'(bus.RLEVEL), 3);
      chk("th3_raempty", int'(bus.RAEMPTY), 0);
      chk("th3_rempty", int'(bus.REMPTY), 0);
      chk("th3_ren_cnt", ren_cnt, 2);
      pop_one();
      chk("th2_ren_cnt", ren_cnt, 3);
      chk("th2_rempty", int'(bus.REMPTY), 1);
      chk("th2_rlevel", int'(bus.RLEVEL), 2);
      chk("th2_raempty", int'(bus.RAEMPTY), 1);
      step(3);
      pop_one();
      step(2);
      chk("th1_rlevel", int'(bus.RLEVEL), 1);
      chk("th1_raempty", int'(bus.RAEMPTY), 1);
      pop_one();
      step(2);
      chk("th0_rlevel", int'(bus.RLEVEL), 0);
      chk("th0_rvalid", int'(bus.RVALID), 0);
      chk("th0_raempty", int'(bus.RAEMPTY), 1);
      chk("th0_leftover", exp_q.size(), 0);

      // Asynchronous reset with a read in flight and one word buffered.
      do_reset();
      for (int i = 0; i < 3; i++) write_word(8'(8'h20 + i));
      k = 0;
      while (!(dut.pend_q && dut.bcnt == 2'd1) && k < 20) begin
         step();
         k++;
      end
      chk("mid_reach_state", int'(dut.pend_q && dut.bcnt == 2'd1), 1);
      #2 RRST = 1'b1;
      #1 chk_reset_outputs("mid");
      chk("mid_bcnt", int'(dut.bcnt), 0);
      chk("mid_pend", int'(dut.pend_q), 0);
      bus.RQ2_WPTR = '0;
      wbin         = '0;
      exp_q.delete();
      step(1);
      RRST = 1'b0;
      clear_mon();
      step(5);
      chk("post_valid_seen", int'(valid_seen), 0);
      chk("post_ren_cnt", ren_cnt, 0);
      bus.RREADY = 1'b1;
      write_word(8'h5A);
      drain(10);
      step(2);
      chk("post_ren_once", ren_cnt, 1);
      if (ren_addr.size() >= 1) chk("post_first_raddr", ren_addr[0], 0);
      else chk("post_raddr_cnt", ren_addr.size(), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
